// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package if_pkg;

  localparam int IF_INSTR_W = 32;

  // Source of a PC redirect; NONE means sequential fetch.
  typedef enum logic [2:0] {
    NONE = 3'd0,
    PRED = 3'd1,
    PCI  = 3'd2,
    PCR  = 3'd3,
    UNDO = 3'd4,
    IRQ  = 3'd5
  } redirect_src_e;

  function automatic logic is_redirect(redirect_src_e src);
    return src != NONE;
  endfunction

  // Saturating 32-bit increment for event counters.
  function automatic logic [31:0] sat_inc32(logic [31:0] v, logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/if_sync_fifo.sv
// Synchronous FIFO with a synchronous flush; DEPTH must be a power of 2.
module if_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = mem_q[rd_ptr_q];

  // Pointer/count update; flush discards everything including this cycle's push/pop.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & ((cnt_q != FULL_CNT) | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (PW+1)'(1);
        2'b01:   cnt_d = cnt_q - (PW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC ownership, pipelined memory requests, in-order
// (pc, instr) buffer towards decode, redirect flush and maskable interrupt.
// Optional macro IF_PERF_CNT_EN adds saturating performance counters.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] IRQ_VEC   = ADDR_W'('h100),
  parameter int                PC_INC    = 4,
  parameter int                BUF_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  alert,
  input  logic                  interrupt_mask,
  input  logic                  branch_predict,
  input  logic                  pci_take,
  input  logic                  pcr_take,
  input  logic                  branch_undo,
  input  logic [ADDR_W-1:0]     branch_pc,
  input  logic [ADDR_W-1:0]     pcr,
  input  logic [ADDR_W-1:0]     pc_not_taken,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [IF_INSTR_W-1:0] mem_rdata,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [ADDR_W-1:0]     if_pc,
  output logic [IF_INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]     if_pc_plus_4,
  output logic                  interrupt,
  output logic [ADDR_W-1:0]     epc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cyc,
  output logic [31:0]           perf_redirects,
  output logic [31:0]           perf_dropped
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  // Discards can accumulate across back-to-back redirects, so give headroom.
  localparam int DW    = CNT_W + 4;
  localparam int ENT_W = ADDR_W + IF_INSTR_W;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(BUF_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              irq_pending_q, irq_pending_d;
  logic              interrupt_q, interrupt_d;
  logic [DW-1:0]     discard_q, discard_d;

  redirect_src_e     src;
  logic [ADDR_W-1:0] tgt;
  logic              irq_take, redirect;
  logic [CNT_W-1:0]  pcq_cnt, buf_cnt;
  logic [CNT_W:0]    occ;
  logic              pcq_empty, buf_empty;
  logic [ADDR_W-1:0] pcq_head;
  logic [ENT_W-1:0]  buf_rdata;
  logic              gnt_fire, resp_keep, resp_drop;
  logic [DW-1:0]     inflight;

  // Redirect arbitration: interrupt first, then the fixed branch priority.
  always_comb begin
    irq_take = (irq_pending_q | alert) & ~interrupt_mask;
    src      = NONE;
    tgt      = pc_q;
    if (irq_take) begin
      src = IRQ;  tgt = IRQ_VEC;
    end else if (branch_undo) begin
      src = UNDO; tgt = pc_not_taken;
    end else if (pcr_take) begin
      src = PCR;  tgt = pcr;
    end else if (pci_take) begin
      src = PCI;  tgt = branch_pc;
    end else if (branch_predict) begin
      src = PRED; tgt = branch_pc;
    end
  end

  assign redirect = is_redirect(src);

  // Credit: every live request must have a guaranteed buffer slot.
  assign occ       = {1'b0, pcq_cnt} + {1'b0, buf_cnt};
  assign mem_req   = ~stall & ~redirect & (occ < DEPTH_L);
  assign mem_addr  = pc_q;
  assign gnt_fire  = mem_req & mem_gnt;
  assign resp_keep = mem_rvalid & ~redirect & (discard_q == '0) & ~pcq_empty;
  assign inflight  = discard_q + DW'(pcq_cnt);
  assign resp_drop = mem_rvalid & ((discard_q != '0) | (redirect & (pcq_cnt != '0)));

  // Next PC, interrupt bookkeeping and stale-response accounting.
  always_comb begin
    pc_d          = pc_q;
    epc_d         = epc_q;
    interrupt_d   = irq_take;
    irq_pending_d = (irq_pending_q | alert) & ~irq_take;
    discard_d     = discard_q;
    if (redirect) begin
      pc_d = tgt;
      if (irq_take) epc_d = pc_q;
      // Everything in flight becomes stale, including a response landing now.
      discard_d = (mem_rvalid && inflight != '0) ? inflight - DW'(1) : inflight;
    end else begin
      if (gnt_fire) pc_d = pc_q + ADDR_W'(PC_INC);
      if (mem_rvalid && discard_q != '0) discard_d = discard_q - DW'(1);
    end
  end

  // Architectural state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_VEC;
      epc_q         <= '0;
      irq_pending_q <= 1'b0;
      interrupt_q   <= 1'b0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      irq_pending_q <= irq_pending_d;
      interrupt_q   <= interrupt_d;
      discard_q     <= discard_d;
    end
  end

  // PCs of granted, not yet answered requests, in issue order.
  if_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(BUF_DEPTH)) u_pc_q (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (gnt_fire),
    .wdata (pc_q),
    .pop   (resp_keep),
    .rdata (pcq_head),
    .empty (pcq_empty),
    .count (pcq_cnt)
  );

  // Decoded-ready (pc, instr) pairs waiting for decode.
  if_sync_fifo #(.WIDTH(ENT_W), .DEPTH(BUF_DEPTH)) u_out_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (resp_keep),
    .wdata ({pcq_head, mem_rdata}),
    .pop   (if_valid & if_ready),
    .rdata (buf_rdata),
    .empty (buf_empty),
    .count (buf_cnt)
  );

  assign if_valid          = ~buf_empty;
  assign {if_pc, if_instr} = buf_rdata;
  assign if_pc_plus_4      = if_pc + ADDR_W'(PC_INC);
  assign interrupt         = interrupt_q;
  assign epc               = epc_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_redir_q, perf_redir_d;
  logic [31:0] perf_drop_q,  perf_drop_d;

  // Event counters saturate instead of wrapping.
  always_comb begin
    perf_stall_d = sat_inc32(perf_stall_q, stall);
    perf_redir_d = sat_inc32(perf_redir_q, redirect);
    perf_drop_d  = sat_inc32(perf_drop_q,  resp_drop);
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_redir_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_redir_q <= perf_redir_d;
      perf_drop_q  <= perf_drop_d;
    end
  end

  assign perf_stall_cyc = perf_stall_q;
  assign perf_redirects = perf_redir_q;
  assign perf_dropped   = perf_drop_q;
`else
  // Dropped-response indication only feeds the optional counters.
  logic unused_drop;
  assign unused_drop = resp_drop;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-bench memory, queue-based reference model,
// directed scenarios with literal expectations, then a randomized soak.
module tb_if_fetch_unit;

  localparam int          AW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RST_V = 32'h0;
  localparam logic [31:0] IRQ_V = 32'h100;
  localparam logic [31:0] INC   = 32'd4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic stall = 0, alert = 0, interrupt_mask = 0;
  logic branch_predict = 0, pci_take = 0, pcr_take = 0, branch_undo = 0;
  logic [AW-1:0] branch_pc = '0, pcr = '0, pc_not_taken = '0;
  logic mem_req, mem_gnt = 0, mem_rvalid = 0;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic if_valid, if_ready = 1;
  logic [AW-1:0] if_pc, if_pc_plus_4, epc;
  logic [31:0] if_instr;
  logic interrupt;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_redirects, perf_dropped;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(.ADDR_W(AW), .RESET_VEC(RST_V), .IRQ_VEC(IRQ_V),
                  .PC_INC(4), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .alert(alert),
    .interrupt_mask(interrupt_mask), .branch_predict(branch_predict),
    .pci_take(pci_take), .pcr_take(pcr_take), .branch_undo(branch_undo),
    .branch_pc(branch_pc), .pcr(pcr), .pc_not_taken(pc_not_taken),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_instr(if_instr), .if_pc_plus_4(if_pc_plus_4),
    .interrupt(interrupt), .epc(epc)
`ifdef IF_PERF_CNT_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_redirects(perf_redirects),
    .perf_dropped(perf_dropped)
`endif
  );

  int checks = 0, errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory transactions in issue order; keep=0 once a redirect made them stale.
  typedef struct { logic [31:0] addr; bit keep; int ready; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  mreq_t memq[$];
  ent_t  bufq[$];
  logic [31:0] m_pc, m_epc;
  bit m_pend, m_int;
  int cyc, grants;
  int gnt_pct = 100, rv_pct = 100, lat_min = 1, lat_max = 1;

  logic [31:0] popped[$];
  int          popped_cyc[$];
  logic        obs_req, obs_int;
  logic [31:0] obs_addr, obs_epc;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: memory drives, outputs are checked, model advances.
  task automatic step();
    bit resp_now, take, redir, mreq;
    int kept;
    mreq_t e;
    logic [31:0] tgt;
    resp_now = (memq.size() > 0) && (memq[0].ready <= cyc) &&
               ($urandom_range(99) < rv_pct);
    mem_rvalid = resp_now;
    mem_rdata  = resp_now ? instr_of(memq[0].addr) : $urandom;
    mem_gnt    = 1'b0;
    #1;
    take  = (m_pend || alert) && !interrupt_mask;
    redir = take || branch_undo || pcr_take || pci_take || branch_predict;
    kept  = 0;
    foreach (memq[i]) if (memq[i].keep) kept++;
    mreq = !stall && !redir && (kept + bufq.size() < DEPTH);
    chk("mem_req", mem_req, mreq);
    if (mreq) chk("mem_addr", mem_addr, m_pc);
    chk("if_valid", if_valid, bufq.size() > 0);
    if (bufq.size() > 0) begin
      chk("if_pc", if_pc, bufq[0].pc);
      chk("if_instr", if_instr, bufq[0].ins);
      chk("if_pc_plus_4", if_pc_plus_4, bufq[0].pc + INC);
    end
    chk("interrupt", interrupt, m_int);
    chk("epc", epc, m_epc);
    obs_req = mem_req; obs_addr = mem_addr; obs_int = interrupt; obs_epc = epc;
    if (if_valid && if_ready) begin
      popped.push_back(if_pc);
      popped_cyc.push_back(cyc);
    end
    mem_gnt = mem_req && ($urandom_range(99) < gnt_pct);
    // model update
    if (bufq.size() > 0 && if_ready) void'(bufq.pop_front());
    if (resp_now) begin
      e = memq.pop_front();
      if (e.keep && !redir) bufq.push_back('{e.addr, instr_of(e.addr)});
    end
    if (redir) begin
      bufq.delete();
      foreach (memq[i]) memq[i].keep = 1'b0;
      if (take)                tgt = IRQ_V;
      else if (branch_undo)    tgt = pc_not_taken;
      else if (pcr_take)       tgt = pcr;
      else                     tgt = branch_pc;
      if (take) m_epc = m_pc;
      m_pc = tgt;
    end else if (mem_gnt && mreq) begin
      grants++;
      memq.push_back('{m_pc, 1'b1, cyc + $urandom_range(lat_max, lat_min)});
      m_pc = m_pc + INC;
    end
    m_int  = take;
    m_pend = (m_pend || alert) && !take;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 0; alert = 0; interrupt_mask = 0; branch_predict = 0;
    pci_take = 0; pcr_take = 0; branch_undo = 0; if_ready = 1;
    mem_gnt = 0; mem_rvalid = 0;
    memq.delete(); bufq.delete(); popped.delete(); popped_cyc.delete();
    m_pc = RST_V; m_epc = '0; m_pend = 0; m_int = 0; grants = 0; cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_valid", if_valid, 0);
    chk("rst_interrupt", interrupt, 0);
    chk("rst_epc", epc, 0);
    chk("rst_mem_addr", mem_addr, RST_V);
    rst_n = 1'b1;
  endtask

  initial begin
    // Sequential fetch with a 1-cycle memory.
    do_reset();
    repeat (8) step();
    chk("seq_count", popped.size() >= 4, 1);
    for (int k = 0; k < 4; k++) begin
      chk("seq_pc", popped[k], 32'(4 * k));
      chk("seq_cyc", popped_cyc[k], 2 + k);
    end

    // Stall two cycles with pc at 8.
    do_reset();
    step(); step();
    stall = 1;
    step();
    chk("stall_req", obs_req, 0);
    chk("stall_addr", obs_addr, 8);
    step();
    chk("stall_hold", obs_addr, 8);
    stall = 0;
    repeat (10) step();
    for (int k = 0; k < 5; k++) chk("stall_seq", popped[k], 32'(4 * k));

    // Predicted branch with two requests still in flight.
    do_reset();
    lat_min = 3; lat_max = 3;
    step(); step();
    branch_predict = 1; branch_pc = 32'd10;
    step();
    chk("pred_req", obs_req, 0);
    branch_predict = 0;
    popped.delete();
    repeat (12) step();
    chk("pred_first", popped[0], 32'd10);
    chk("pred_second", popped[1], 32'd14);
    lat_min = 1; lat_max = 1;

    // branch_undo outranks pcr_take.
    do_reset();
    step(); step();
    branch_undo = 1; pcr_take = 1; pc_not_taken = 32'd20; pcr = 32'd30;
    step();
    chk("undo_req", obs_req, 0);
    branch_undo = 0; pcr_take = 0;
    step();
    chk("undo_addr", obs_addr, 32'd20);

    // Decode back-pressure: requests limited by buffer depth, none lost.
    do_reset();
    if_ready = 0;
    repeat (6) step();
    chk("bp_grants", grants, DEPTH);
    if_ready = 1;
    repeat (10) step();
    for (int k = 0; k < 4; k++) chk("bp_seq", popped[k], 32'(4 * k));

    // Masked interrupt held pending, taken on unmask at pc 40.
    do_reset();
    pci_take = 1; branch_pc = 32'd40;
    step();
    pci_take = 0; stall = 1; alert = 1; interrupt_mask = 1;
    step();
    alert = 0;
    step(); step();
    chk("irq_masked", obs_int, 0);
    chk("irq_masked_addr", obs_addr, 32'd40);
    interrupt_mask = 0;
    step();
    step();
    chk("irq_pulse", obs_int, 1);
    chk("irq_epc", obs_epc, 32'd40);
    chk("irq_addr", obs_addr, IRQ_V);
    step();
    chk("irq_once", obs_int, 0);
    stall = 0;

    // Randomized soak against the model.
    do_reset();
    gnt_pct = 70; rv_pct = 75; lat_min = 1; lat_max = 3;
    for (int n = 0; n < 3000; n++) begin
      stall          = ($urandom_range(99) < 15);
      if_ready       = ($urandom_range(99) < 70);
      alert          = ($urandom_range(99) < 3);
      interrupt_mask = ($urandom_range(99) < 40);
      branch_predict = ($urandom_range(99) < 3);
      pci_take       = ($urandom_range(99) < 2);
      pcr_take       = ($urandom_range(99) < 2);
      branch_undo    = ($urandom_range(99) < 2);
      branch_pc      = {$urandom_range(1023), 2'b00};
      pcr            = {$urandom_range(1023), 2'b00};
      pc_not_taken   = {$urandom_range(1023), 2'b00};
      step();
    end
    chk("rand_activity", grants > 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
